// File: rtl/half_adder_reg_pkg.sv
// Shared half-adder arithmetic: default lane/counter widths and a vector half-add
// that returns {carry, sum} so wider adder blocks can reuse it.
package half_adder_reg_pkg;

    localparam int HA_WIDTH = 1;
    localparam int HA_CNT_W = 16;
    // Widest vector ha_sum handles; narrower operands are zero-extended by the caller.
    localparam int HA_MAX_W = 64;

    function automatic logic [2*HA_MAX_W-1:0] ha_sum(
        input logic [HA_MAX_W-1:0] a,
        input logic [HA_MAX_W-1:0] b
    );
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/half_adder_lane.sv
// One 1-bit half-adder lane: s = a ^ b, c = a & b.
// Latency: combinational.
// Backpressure: none, pure logic.
module half_adder_lane
    import half_adder_reg_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/half_adder_reg.sv
// Registered WIDTH-lane half-adder bank with a saturating carry-event counter.
// Latency: 1 cycle from input accept to out_valid.
// Backpressure: output register plus one skid entry; in_ready is registered and drops while the skid entry is full.
module half_adder_reg
    import half_adder_reg_pkg::*;
#(
    parameter int WIDTH = HA_WIDTH,
    parameter int CNT_W = HA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c,
    output logic [CNT_W-1:0] carry_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] s;
    } res_t;

    logic [WIDTH-1:0] lane_s;
    logic [WIDTH-1:0] lane_c;
    res_t             new_dat;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_lane u_lane (
            .a (a[i]),
            .b (b[i]),
            .s (lane_s[i]),
            .c (lane_c[i])
        );
    end

    assign new_dat = '{c: lane_c, s: lane_s};

    res_t out_dat,  out_dat_nxt;
    res_t skid_dat, skid_dat_nxt;
    logic out_vld,  out_vld_nxt;
    logic skid_vld, skid_vld_nxt;
    logic in_rdy_q;
    logic in_acc;
    logic any_carry;

    assign in_acc = in_valid && in_rdy_q;

    // Upper half of the ha_sum result is the carry vector.
    assign any_carry = |(ha_sum(HA_MAX_W'(a), HA_MAX_W'(b)) >> HA_MAX_W);

    always_comb begin
        out_dat_nxt  = out_dat;
        out_vld_nxt  = out_vld;
        skid_dat_nxt = skid_dat;
        skid_vld_nxt = skid_vld;
        if (!out_vld || out_ready) begin
            // Output slot frees this cycle: skid refills it first to keep order.
            if (skid_vld) begin
                out_dat_nxt  = skid_dat;
                out_vld_nxt  = 1'b1;
                skid_vld_nxt = 1'b0;
            end else if (in_acc) begin
                out_dat_nxt = new_dat;
                out_vld_nxt = 1'b1;
            end else begin
                out_vld_nxt = 1'b0;
            end
        end else if (in_acc) begin
            skid_dat_nxt = new_dat;
            skid_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_dat   <= '0;
            out_vld   <= 1'b0;
            skid_dat  <= '0;
            skid_vld  <= 1'b0;
            in_rdy_q  <= 1'b0;
            carry_cnt <= '0;
        end else begin
            out_dat  <= out_dat_nxt;
            out_vld  <= out_vld_nxt;
            skid_dat <= skid_dat_nxt;
            skid_vld <= skid_vld_nxt;
            in_rdy_q <= !skid_vld_nxt;
            if (in_acc && any_carry && (carry_cnt != {CNT_W{1'b1}})) begin
                carry_cnt <= carry_cnt + CNT_W'(1);
            end
        end
    end

    assign in_ready  = in_rdy_q;
    assign out_valid = out_vld;
    assign s         = out_dat.s;
    assign c         = out_dat.c;

endmodule

// File: tb/tb_half_adder_reg.sv
// Scoreboard bench: a 1-lane/2-bit-counter instance and a 4-lane/16-bit-counter
// instance share one handshake; lane 0 of the operands feeds the 1-lane instance.
module tb_half_adder_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic [3:0]  se_r = '0;
    logic [3:0]  ce_r = '0;

    logic        in_rdy1, out_valid1;
    logic [0:0]  s1, c1;
    logic [1:0]  cnt1;
    logic        in_rdy4, out_valid4;
    logic [3:0]  s4, c4;
    logic [15:0] cnt4;

    always #5 clk = ~clk;

    half_adder_reg #(.WIDTH(1), .CNT_W(2)) u_w1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_rdy1),
        .a         (a4[0:0]),
        .b         (b4[0:0]),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .s         (s1),
        .c         (c1),
        .carry_cnt (cnt1)
    );

    half_adder_reg #(.WIDTH(4), .CNT_W(16)) u_w4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_rdy4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready),
        .s         (s4),
        .c         (c4),
        .carry_cnt (cnt4)
    );

    typedef struct {
        logic [3:0] s;
        logic [3:0] c;
        int         cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   cnt1_m = 0;
    int   cnt4_m = 0;
    bit   lat_chk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge with inputs settled: books what the next rising edge transfers.
    task automatic tick();
        exp_t e;
        chk("cnt_w1", 32'(cnt1), 32'(cnt1_m));
        chk("cnt_w4", 32'(cnt4), 32'(cnt4_m));
        if (in_valid && in_rdy4) begin
            e.s = se_r; e.c = ce_r; e.cyc = cyc;
            q4.push_back(e);
            if ((|ce_r) && cnt4_m != 65535) cnt4_m++;
        end
        if (in_valid && in_rdy1) begin
            e.s = {3'b000, se_r[0]}; e.c = {3'b000, ce_r[0]}; e.cyc = cyc;
            q1.push_back(e);
            if (ce_r[0] && cnt1_m != 3) cnt1_m++;
        end
        if (out_valid4 && out_ready) begin
            if (q4.size() == 0) chk("spurious_w4", 32'(out_valid4), 32'(0));
            else begin
                e = q4.pop_front();
                chk("s_w4", 32'(s4), 32'(e.s));
                chk("c_w4", 32'(c4), 32'(e.c));
                if (lat_chk) chk("lat_w4", 32'(cyc - e.cyc), 32'(1));
            end
        end
        if (out_valid1 && out_ready) begin
            if (q1.size() == 0) chk("spurious_w1", 32'(out_valid1), 32'(0));
            else begin
                e = q1.pop_front();
                chk("s_w1", 32'(s1), 32'(e.s));
                chk("c_w1", 32'(c1), 32'(e.c));
                if (lat_chk) chk("lat_w1", 32'(cyc - e.cyc), 32'(1));
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send(input logic [3:0] a_i, input logic [3:0] b_i,
                        input logic [3:0] s_e, input logic [3:0] c_e);
        bit acc = 1'b0;
        in_valid = 1'b1; a4 = a_i; b4 = b_i; se_r = s_e; ce_r = c_e;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = in_rdy4;
            tick();
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (q1.size() != 0 || q4.size() != 0); k++) tick();
        chk("drain_w1", 32'(q1.size()), 32'(0));
        chk("drain_w4", 32'(q4.size()), 32'(0));
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        in_valid = 1'b0;
        q1.delete(); q4.delete();
        cnt1_m = 0; cnt4_m = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cyc += 2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] tt_a [4];
        logic [3:0] tt_b [4];
        logic [3:0] tt_s [4];
        logic [3:0] tt_c [4];
        int         sat_exp [5];
        logic [3:0] ra, rb;

        tt_a = '{4'h0, 4'h1, 4'h0, 4'h1};
        tt_b = '{4'h0, 4'h0, 4'h1, 4'h1};
        tt_s = '{4'h0, 4'h1, 4'h1, 4'h0};
        tt_c = '{4'h0, 4'h0, 4'h0, 4'h1};
        sat_exp = '{1, 2, 3, 3, 3};

        // Reset state while rst is held
        @(negedge clk);
        chk("rst_out_valid", 32'({out_valid1, out_valid4}), 32'(0));
        chk("rst_sc_w1", 32'({s1, c1}), 32'(0));
        chk("rst_sc_w4", 32'({s4, c4}), 32'(0));
        chk("rst_cnt", 32'({cnt1, cnt4}), 32'(0));
        chk("rst_in_ready", 32'({in_rdy1, in_rdy4}), 32'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'({in_rdy1, in_rdy4}), 32'(3));

        // Truth table, one vector per cycle
        out_ready = 1'b1;
        lat_chk = 1'b1;
        for (int i = 0; i < 4; i++) send(tt_a[i], tt_b[i], tt_s[i], tt_c[i]);
        drain();
        chk("tt_cnt_w1", 32'(cnt1), 32'(1));
        chk("tt_cnt_w4", 32'(cnt4), 32'(1));

        // Four lanes
        reset_dut();
        send(4'b1100, 4'b1010, 4'b0110, 4'b1000);
        send(4'hF, 4'h0, 4'hF, 4'h0);
        drain();
        chk("lanes_cnt_w4", 32'(cnt4), 32'(1));

        // Backpressure: first result stalls, second parks in the skid entry
        reset_dut();
        lat_chk = 1'b0;
        out_ready = 1'b0;
        send(4'h1, 4'h1, 4'h0, 4'h1);
        chk("bp_first_w1", 32'({out_valid1, s1, c1}), 32'(3'b101));
        send(4'h1, 4'h0, 4'h1, 4'h0);
        chk("bp_in_ready", 32'({in_rdy1, in_rdy4}), 32'(0));
        chk("bp_hold_w1", 32'({out_valid1, s1, c1}), 32'(3'b101));
        tick();
        chk("bp_hold2_w1", 32'({out_valid1, s1, c1}), 32'(3'b101));
        chk("bp_in_ready2", 32'(in_rdy1), 32'(0));
        out_ready = 1'b1;
        tick();
        chk("bp_second_w1", 32'({out_valid1, s1, c1}), 32'(3'b110));
        chk("bp_ready_back", 32'({in_rdy1, in_rdy4}), 32'(3));
        tick();
        chk("bp_empty_w1", 32'(out_valid1), 32'(0));

        // Streaming: eight back-to-back vectors
        reset_dut();
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            send(ra, rb, ra ^ rb, ra & rb);
            if (i > 0) chk("stream_valid", 32'({out_valid1, out_valid4}), 32'(3));
        end
        chk("stream_valid_last", 32'({out_valid1, out_valid4}), 32'(3));
        drain();

        // Reset mid-operation with two results held
        reset_dut();
        lat_chk = 1'b0;
        out_ready = 1'b0;
        send(4'h1, 4'h1, 4'h0, 4'h1);
        send(4'h1, 4'h1, 4'h0, 4'h1);
        chk("pre_rst_cnt_w1", 32'(cnt1), 32'(2));
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'({out_valid1, out_valid4}), 32'(0));
        chk("arst_sc", 32'({s1, c1, s4, c4}), 32'(0));
        chk("arst_cnt", 32'({cnt1, cnt4}), 32'(0));
        chk("arst_in_ready", 32'({in_rdy1, in_rdy4}), 32'(0));
        q1.delete(); q4.delete();
        cnt1_m = 0; cnt4_m = 0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("arst_release_ready", 32'({in_rdy1, in_rdy4}), 32'(3));
        for (int k = 0; k < 4; k++) tick();
        chk("no_stale", 32'({out_valid1, out_valid4}), 32'(0));

        // Counter saturation on the 2-bit counter
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            send(4'h1, 4'h1, 4'h0, 4'h1);
            chk("sat_cnt_w1", 32'(cnt1), 32'(sat_exp[i]));
        end
        drain();
        chk("sat_cnt_w4", 32'(cnt4), 32'(5));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
